// File: rtl/keypad_debounce.sv
// keypad_debounce: input conditioner for the microwave keypad, start/stop button
// and door switch. Each raw input is synchronised through two flops, then
// debounced by a per-input counter. The clean key vector drives a small FSM
// that emits one-hot key strobes, rejects multi-key presses, and waits for a
// full release before accepting the next press.
module keypad_debounce #(
  parameter int NKEYS  = 10,
  parameter int DB_CNT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  input  logic             btn_raw,
  input  logic             door_raw,
  output logic [NKEYS-1:0] keypad,
  output logic             key_valid,
  output logic             start_stop,
  output logic             door_sensor,
  output logic             multi_err
);

  localparam int CW    = $clog2(DB_CNT + 1);
  localparam int NIN   = NKEYS + 2;          // keys, then button, then door
  localparam int BTN   = NKEYS;
  localparam int DOOR  = NKEYS + 1;
  localparam int PCW   = $clog2(NKEYS + 1);

  // Idle value of every conditioned input: keys and button released, door open.
  localparam logic [NIN-1:0] RST_VAL = {1'b1, 1'b0, {NKEYS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } key_state_e;

  logic [NIN-1:0] sync1_q;
  logic [NIN-1:0] sync2_q;
  logic [NIN-1:0] stable_q;
  logic [NIN-1:0] stable_d;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];

  key_state_e     state_q;
  logic [NKEYS-1:0] keypad_q;
  logic           key_valid_q;
  logic           multi_err_q;
  logic           start_stop_q;
  logic           btn_prev_q;
  logic           door_sensor_q;

  logic [NKEYS-1:0] keys_s;
  logic [PCW-1:0]   key_cnt_s;

  // Count of keys currently held in the debounced vector.
  function automatic logic [PCW-1:0] popcount(input logic [NKEYS-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (v[i]) begin
        n = n + PCW'(1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  assign keys_s    = stable_q[NKEYS-1:0];
  assign key_cnt_s = popcount(keys_s);

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= {door_raw, btn_raw, key_raw};
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: a differing input must persist DB_CNT cycles to flip.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DB_CNT - 1)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= RST_VAL;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Key FSM: strobe a single clean press, flag multi-key, hold off until release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      keypad_q    <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      keypad_q    <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_cnt_s == PCW'(1)) begin
            keypad_q    <= keys_s;
            key_valid_q <= 1'b1;
            state_q     <= ST_PRESS;
          end else if (key_cnt_s > PCW'(1)) begin
            multi_err_q <= 1'b1;
            state_q     <= ST_HELD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PRESS: begin
          state_q <= ST_HELD;
        end
        ST_HELD: begin
          if (keys_s == '0) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_HELD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Start/stop strobe on a debounced press edge; door level registered out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev_q    <= 1'b0;
      start_stop_q  <= 1'b0;
      door_sensor_q <= 1'b1;
    end else begin
      btn_prev_q    <= stable_q[BTN];
      start_stop_q  <= stable_q[BTN] & ~btn_prev_q;
      door_sensor_q <= stable_q[DOOR];
    end
  end

  assign keypad      = keypad_q;
  assign key_valid   = key_valid_q;
  assign multi_err   = multi_err_q;
  assign start_stop  = start_stop_q;
  assign door_sensor = door_sensor_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with DB_CNT=4: a table of input records
// with the outputs expected after the record's last clock, plus a hand-written
// asynchronous reset sequence. Strobe outputs must stay low on every cycle of
// a record except where the record's final expectation says otherwise.
module tb_keypad_debounce;

  localparam int NKEYS  = 10;
  localparam int DB_CNT = 4;

  logic             clk;
  logic             rst;
  logic [NKEYS-1:0] key_raw;
  logic             btn_raw;
  logic             door_raw;
  logic [NKEYS-1:0] keypad;
  logic             key_valid;
  logic             start_stop;
  logic             door_sensor;
  logic             multi_err;

  int nvec;
  int nerr;

  typedef struct {
    logic [NKEYS-1:0] key;
    logic             btn;
    logic             door;
    int               n;
    logic [NKEYS-1:0] e_key;
    logic             e_valid;
    logic             e_ss;
    logic             e_door;
    logic             e_err;
  } vec_t;

  vec_t tbl[$];
  int   split;

  keypad_debounce #(.NKEYS(NKEYS), .DB_CNT(DB_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .btn_raw    (btn_raw),
    .door_raw   (door_raw),
    .keypad     (keypad),
    .key_valid  (key_valid),
    .start_stop (start_stop),
    .door_sensor(door_sensor),
    .multi_err  (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d required completion", nvec);
    $fatal(1, "timeout");
  end

  task automatic add(input logic [NKEYS-1:0] k, input logic b, input logic d, input int n,
                     input logic [NKEYS-1:0] ek, input logic ev, input logic es,
                     input logic ed, input logic ee);
    vec_t v;
    v.key = k; v.btn = b; v.door = d; v.n = n;
    v.e_key = ek; v.e_valid = ev; v.e_ss = es; v.e_door = ed; v.e_err = ee;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [NKEYS-1:0] ek, input logic ev,
                           input logic es, input logic ed, input logic ee);
    nvec++;
    if (keypad !== ek || key_valid !== ev || start_stop !== es ||
        door_sensor !== ed || multi_err !== ee) begin
      nerr++;
      $display("FAIL %s: got keypad=%h valid=%b ss=%b door=%b err=%b, want keypad=%h valid=%b ss=%b door=%b err=%b",
               name, keypad, key_valid, start_stop, door_sensor, multi_err, ek, ev, es, ed, ee);
    end
  endtask

  task automatic check_quiet(input string name);
    nvec++;
    if (keypad !== '0 || key_valid !== 1'b0 || start_stop !== 1'b0 || multi_err !== 1'b0) begin
      nerr++;
      $display("FAIL %s: got keypad=%h valid=%b ss=%b err=%b, want all strobes 0",
               name, keypad, key_valid, start_stop, multi_err);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    key_raw  = v.key;
    btn_raw  = v.btn;
    door_raw = v.door;
    for (int s = 0; s < v.n - 1; s++) begin
      step();
      check_quiet($sformatf("vec%0d_cyc%0d", idx, s));
    end
    step();
    check_all($sformatf("vec%0d_end", idx), v.e_key, v.e_valid, v.e_ss, v.e_door, v.e_err);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    // 1: steady key 7, single strobe after edge 6, held 100 cycles, release, repress
    add(10'h080, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h080, 1'b0, 1'b1, 1,   10'h080, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h080, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h080, 1'b0, 1'b1, 100, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h080, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h080, 1'b0, 1'b1, 1,   10'h080, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    // 2: key 3 bounces 1,0,1,0 then steady
    add(10'h008, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h008, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h008, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h008, 1'b0, 1'b1, 1,   10'h008, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    // 3: keys 1 and 2 together -> multi_err, then key 2 alone
    add(10'h006, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h006, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    add(10'h006, 1'b0, 1'b1, 1,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h004, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h004, 1'b0, 1'b1, 1,   10'h004, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    // 4: hold 5, add 6, drop 5, release all, then press 6
    add(10'h020, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h020, 1'b0, 1'b1, 1,   10'h020, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h060, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h040, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h040, 1'b0, 1'b1, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h040, 1'b0, 1'b1, 1,   10'h040, 1'b1, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b1, 20,  10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    // 5: door closes, short open glitch ignored; button press/release
    add(10'h000, 1'b0, 1'b0, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h000, 1'b0, 1'b0, 1,   10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b0, 1'b1, 2,   10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 20,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b1, 1'b0, 6,   10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b1, 1'b0, 1,   10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(10'h000, 1'b1, 1'b0, 5,   10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 20,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    // button and key 0 together: both strobes in the same cycle
    add(10'h001, 1'b1, 1'b0, 6,   10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(10'h001, 1'b1, 1'b0, 1,   10'h001, 1'b1, 1'b1, 1'b0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 20,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    split = tbl.size();
    // 6 tail: after reset release with key 9 still held (door_raw still 0)
    add(10'h200, 1'b0, 1'b0, 6,   10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(10'h200, 1'b0, 1'b0, 1,   10'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    add(10'h000, 1'b0, 1'b0, 20,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    rst      = 1'b0;
    key_raw  = '0;
    btn_raw  = 1'b0;
    door_raw = 1'b1;
    step();
    step();
    check_all("reset_state", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check_all("post_reset_idle", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < split; i++) begin
      run_vec(i);
    end

    // 6: reset in the middle of key 9 debounce (counter at 2)
    key_raw  = 10'h200;
    btn_raw  = 1'b0;
    door_raw = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      check_quiet($sformatf("mid_db_cyc%0d", s));
    end
    check_all("pre_reset_door", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_all("async_reset", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check_all("reset_held", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;

    for (int i = split; i < tbl.size(); i++) begin
      run_vec(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
